// File: rtl/wide_packer_if.sv
// Handshake bundle between a narrow-word producer, the packer and a wide-word consumer.
// in_last_i exists only when WIDE_PACKER_FLUSH_EN is defined.
interface wide_packer_if #(
  parameter int INPUT_W  = 32,
  parameter int OUTPUT_W = 64
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [INPUT_W-1:0]  in_data_i;
`ifdef WIDE_PACKER_FLUSH_EN
  logic                in_last_i;
`endif
  logic                out_valid_o;
  logic                out_ready_i;
  logic [OUTPUT_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
`ifdef WIDE_PACKER_FLUSH_EN
    input  in_last_i,
`endif
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
`ifdef WIDE_PACKER_FLUSH_EN
    output in_last_i,
`endif
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/wide_packer.sv
// Packs RATIO = OUTPUT_W/INPUT_W narrow words into one wide word, word 0 in the low bits.
// WIDE_PACKER_FLUSH_EN adds in_last_i: a last word closes the group and zero-fills the rest.
module wide_packer_slice #(
  parameter int W     = 32,
  parameter int CNT_W = 1,
  parameter int IDX   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     fill_o,
  output logic [W-1:0]     packed_o
);
  localparam logic [CNT_W-1:0] K = CNT_W'(IDX);

  // Slots below the counter are already filled, the current slot takes the
  // incoming word, slots above are only reachable on a flush and read zero.
  always_comb begin
    packed_o = '0;
    if (K < cnt_i)       packed_o = fill_o;
    else if (K == cnt_i) packed_o = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                        fill_o <= '0;
    else if (accept_i && K == cnt_i)  fill_o <= data_i;
  end
endmodule

module wide_packer #(
  parameter int INPUT_W  = 32,
  parameter int OUTPUT_W = 64
) (
  input logic          clk_i,
  input logic          rst_i,
  wide_packer_if.slave bus
);
  localparam int RATIO = OUTPUT_W / INPUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((OUTPUT_W % INPUT_W) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_cfg
    $error("wide_packer: OUTPUT_W/INPUT_W must be a power-of-two integer >= 2");
  end

  logic [CNT_W-1:0]                cnt_q;
  logic [RATIO-1:0][INPUT_W-1:0]   fill_q;
  logic [RATIO-1:0][INPUT_W-1:0]   packed_w;
  logic [OUTPUT_W-1:0]             out_q;
  logic                            out_vld_q;
  logic                            last_slot_c;
  logic                            in_ready_c;
  logic                            accept_c;
  logic                            complete_c;

`ifdef WIDE_PACKER_FLUSH_EN
  assign last_slot_c = (cnt_q == CNT_W'(RATIO - 1)) || bus.in_last_i;
`else
  assign last_slot_c = (cnt_q == CNT_W'(RATIO - 1));
`endif

  // Only a completing word needs the output register; it may go in if the
  // register is empty or is being drained this same cycle.
  assign in_ready_c = !(last_slot_c && out_vld_q && !bus.out_ready_i);
  assign accept_c   = bus.in_valid_i && in_ready_c;
  assign complete_c = accept_c && last_slot_c;

  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    wide_packer_slice #(.W(INPUT_W), .CNT_W(CNT_W), .IDX(k)) u_slice (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .accept_i (accept_c),
      .cnt_i    (cnt_q),
      .data_i   (bus.in_data_i),
      .fill_o   (fill_q[k]),
      .packed_o (packed_w[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (accept_c) cnt_q <= complete_c ? '0 : cnt_q + 1'b1;
      if (complete_c) begin
        out_q     <= packed_w;
        out_vld_q <= 1'b1;
      end else if (out_vld_q && bus.out_ready_i) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = in_ready_c;
  assign bus.out_valid_o = out_vld_q;
  assign bus.out_data_o  = out_q;
endmodule

// File: doc/wide_packer.md
WIDE_PACKER -- requirements
Module: wide_packer

Interface
REQ-001 SHALL have parameter INPUT_W, default 32, meaning width of each narrow input word.
REQ-002 SHALL have parameter OUTPUT_W, default 64, meaning width of the packed output word; RATIO = OUTPUT_W/INPUT_W.
REQ-003 SHALL have parameter CNT_W, derived as ceil(log2(RATIO)), meaning fill-counter width; not overridable.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid_i, input, 1, narrow word present.
REQ-007 SHALL have port in_ready_o, output, 1, packer accepts narrow word this cycle.
REQ-008 SHALL have port in_data_i, input, INPUT_W, narrow word.
REQ-009 SHALL have port in_last_i, input, 1, final word of a burst; present only with WIDE_PACKER_FLUSH_EN.
REQ-010 SHALL have port out_valid_o, output, 1, packed word held in output register.
REQ-011 SHALL have port out_ready_i, input, 1, consumer accepts packed word.
REQ-012 SHALL have port out_data_o, output, OUTPUT_W, packed word.

Function
REQ-013 SHALL require OUTPUT_W an integer multiple of INPUT_W with RATIO a power of two >= 2; elaboration SHALL fail otherwise.
REQ-014 SHALL accept an input word exactly on cycles where in_valid_i and in_ready_o are both 1; output transfer exactly when out_valid_o and out_ready_i are both 1.
REQ-015 SHALL place the k-th accepted word of a group (k = 0..RATIO-1) in bits [k*INPUT_W +: INPUT_W] of the packed word (word 0 in lowest bits).
REQ-016 SHALL hold internal state: fill register (OUTPUT_W), fill counter 0..RATIO-1, output register (OUTPUT_W), out_valid flag.
REQ-017 SHALL increment the fill counter on each accept that does not complete a group; on the completing accept (counter = RATIO-1) the counter SHALL wrap to 0.
REQ-018 SHALL, on the completing accept, load fill register contents plus the completing word into the output register and set out_valid_o on the next cycle (latency 1 cycle from completing accept).
REQ-019 SHALL drive in_ready_o = 0 only when the next accept would complete a group, out_valid_o = 1 and out_ready_i = 0; otherwise in_ready_o = 1.
REQ-020 SHALL, when output transfer and completing accept coincide, load the new packed word and keep out_valid_o = 1 (no bubble).
REQ-021 SHALL clear out_valid_o after an output transfer with no coincident completing accept.
REQ-022 SHALL hold out_data_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-023 SHALL sustain one input word per cycle indefinitely when out_ready_i is held 1.
REQ-024 SHALL ignore in_data_i when no accept occurs; in_ready_o SHALL depend combinationally only on state and out_ready_i, never on in_valid_i.

Reset
REQ-025 SHALL, on rst_i = 1 at a rising edge, set fill counter 0, out_valid_o 0, fill and output registers all-zero; out_data_o reads 0 after reset.
REQ-026 SHALL, on reset mid-group or with output pending, discard partial and pending data; no packed word from pre-reset input SHALL appear afterwards.
REQ-027 SHALL drive in_ready_o = 1 in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL, with macro WIDE_PACKER_FLUSH_EN defined, expose in_last_i; an accept with in_last_i = 1 completes the group regardless of counter, zero-fills all higher unfilled slices, resets counter to 0; REQ-019 uses "accept with in_last_i = 1 or counter = RATIO-1" as the completing condition.
REQ-029 SHALL, without WIDE_PACKER_FLUSH_EN, omit in_last_i; groups complete only at counter = RATIO-1.

Verification (INPUT_W=32, OUTPUT_W=64)
REQ-030 SHALL verify: accept 0x11111111 then 0x22222222 back-to-back, out_ready_i=1 -> out_valid_o=1 one cycle after 2nd accept, out_data_o=0x22222222_11111111, in_ready_o never 0.
REQ-031 SHALL verify: out_ready_i=0, offer words 1,2,3,4 continuously -> words 1-3 accepted, in_ready_o=0 with word 4 offered, out_data_o=0x00000002_00000001 stable; raise out_ready_i -> word 4 accepted same cycle, next out_data_o=0x00000004_00000003, out_valid_o stays 1.
REQ-032 SHALL verify: stream 8 words 0..7, out_ready_i=1 -> 4 packed outputs 0x1_0, 0x3_2, 0x5_4, 0x7_6 on consecutive alternate cycles, no stall.
REQ-033 SHALL verify: accept 0xDEADBEEF, assert rst_i one cycle, then accept 0xA and 0xB -> single output 0x0000000B_0000000A, out_valid_o=0 during and after reset until then.
REQ-034 SHALL verify with WIDE_PACKER_FLUSH_EN: accept 0xAAAA5555 with in_last_i=1 -> out_data_o=0x00000000_AAAA5555 next cycle; following 2 words pack normally from slice 0.
